// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stalls, EX-stage redirects, and drain/halt control.
// Optional performance counters are built when PIPELINE_PERF_COUNTERS_EN is defined.
module pipeline_hazard_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic        want_stall,
   input  logic        ex_branch,
   input  logic        ex_taken,
   input  logic        ex_jal,
   input  logic        ex_jalr,
   input  logic        halt_req,
   input  logic        resume_req,
   output logic        pc_write_enable,
   output logic        no_stall,
   output logic        inject_bubble,
   output logic        flush_id,
   output logic        halted,
   output logic [1:0]  next_pc_select,
   output logic [31:0] cycle_count,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
);

   typedef enum logic [2:0] {
      RUN        = 3'd0,
      LOAD_STALL = 3'd1,
      REDIRECT   = 3'd2,
      DRAIN      = 3'd3,
      HALT       = 3'd4
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] drain_q, drain_d;
   logic       redirect;

   assign redirect = (ex_branch & ex_taken) | ex_jal | ex_jalr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         drain_q <= 2'd0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         RUN: begin
            if (redirect) begin
               state_d = REDIRECT;
            end else if (want_stall) begin
               state_d = LOAD_STALL;
            end else if (halt_req) begin
               state_d = DRAIN;
               drain_d = 2'd3;
            end
         end
         LOAD_STALL: state_d = redirect ? REDIRECT : RUN;
         REDIRECT:   state_d = RUN;
         DRAIN: begin
            // Leave on the cycle the counter reaches zero, giving three drain cycles.
            if (drain_q <= 2'd1) begin
               state_d = HALT;
               drain_d = 2'd0;
            end else begin
               drain_d = drain_q - 2'd1;
            end
         end
         HALT: begin
            if (resume_req) state_d = RUN;
         end
         default: begin
            state_d = RUN;
            drain_d = 2'd0;
         end
      endcase
   end

   always_comb begin
      pc_write_enable = 1'b1;
      no_stall        = 1'b1;
      inject_bubble   = 1'b0;
      flush_id        = 1'b0;
      halted          = 1'b0;
      next_pc_select  = 2'd0;
      if (!reset) begin
         pc_write_enable = 1'b0;
         no_stall        = 1'b0;
         inject_bubble   = 1'b1;
      end else begin
         case (state_q)
            RUN, LOAD_STALL: begin
               if (redirect) begin
                  inject_bubble  = 1'b1;
                  flush_id       = 1'b1;
                  next_pc_select = ex_jalr ? 2'd2 : 2'd1;
               end else if (state_q == RUN && want_stall) begin
                  pc_write_enable = 1'b0;
                  no_stall        = 1'b0;
                  inject_bubble   = 1'b1;
               end else if (state_q == RUN && halt_req) begin
                  pc_write_enable = 1'b0;
                  inject_bubble   = 1'b1;
               end
            end
            REDIRECT: begin
               inject_bubble = 1'b1;
               flush_id      = 1'b1;
            end
            DRAIN: begin
               pc_write_enable = 1'b0;
               no_stall        = 1'b0;
               inject_bubble   = 1'b1;
            end
            HALT: begin
               pc_write_enable = 1'b0;
               no_stall        = 1'b0;
               inject_bubble   = 1'b1;
               halted          = 1'b1;
            end
            default: begin
               pc_write_enable = 1'b0;
               no_stall        = 1'b0;
               inject_bubble   = 1'b1;
            end
         endcase
      end
   end

`ifdef PIPELINE_PERF_COUNTERS_EN
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] stall_q, stall_d;
   logic [31:0] flush_q, flush_d;

   // Saturating counters; they hold at all-ones rather than wrapping.
   always_comb begin
      cycle_d = (cycle_q != 32'hFFFF_FFFF) ? cycle_q + 32'd1 : cycle_q;
      stall_d = (!no_stall && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;
      flush_d = (flush_id && flush_q != 32'hFFFF_FFFF) ? flush_q + 32'd1 : flush_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cycle_q <= 32'd0;
         stall_q <= 32'd0;
         flush_q <= 32'd0;
      end else begin
         cycle_q <= cycle_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign cycle_count = cycle_q;
   assign stall_count = stall_q;
   assign flush_count = flush_q;
`else
   assign cycle_count = 32'd0;
   assign stall_count = 32'd0;
   assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer; counter expectations follow PIPELINE_PERF_COUNTERS_EN.
module tb_pipeline_hazard_sequencer;

`ifdef PIPELINE_PERF_COUNTERS_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        want_stall = 1'b0, ex_branch = 1'b0, ex_taken = 1'b0;
   logic        ex_jal = 1'b0, ex_jalr = 1'b0, halt_req = 1'b0, resume_req = 1'b0;
   logic        pc_write_enable, no_stall, inject_bubble, flush_id, halted;
   logic [1:0]  next_pc_select;
   logic [31:0] cycle_count, stall_count, flush_count;

   int testCount = 0;
   int failCount = 0;
   int expCycles = 0, expStalls = 0, expFlushes = 0;

   pipeline_hazard_sequencer dut (
      .clock(clock), .reset(reset),
      .want_stall(want_stall), .ex_branch(ex_branch), .ex_taken(ex_taken),
      .ex_jal(ex_jal), .ex_jalr(ex_jalr), .halt_req(halt_req), .resume_req(resume_req),
      .pc_write_enable(pc_write_enable), .no_stall(no_stall), .inject_bubble(inject_bubble),
      .flush_id(flush_id), .halted(halted), .next_pc_select(next_pc_select),
      .cycle_count(cycle_count), .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clock = ~clock;

   task automatic applyStimulus(input logic ws, input logic br, input logic tk,
                                input logic jal, input logic jalr,
                                input logic hr, input logic rr);
      want_stall = ws; ex_branch = br; ex_taken = tk;
      ex_jal = jal; ex_jalr = jalr; halt_req = hr; resume_req = rr;
   endtask

   task automatic checkOutput(input string tag, input logic pcwe, input logic ns,
                              input logic bub, input logic fl, input logic hl,
                              input logic [1:0] sel);
      logic [5:0] got, exp;
      got = {pc_write_enable, no_stall, inject_bubble, flush_id, halted, next_pc_select};
      exp = {pcwe, ns, bub, fl, hl, sel};
      testCount++;
      assert (got === exp) else begin
         failCount++;
         $error("[TB] FAIL %s outputs{pcwe,nostall,bubble,flush,halted,sel} got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic checkCounters(input string tag);
      logic [95:0] got, exp;
      got = {cycle_count, stall_count, flush_count};
      exp = PERF ? {32'(expCycles), 32'(expStalls), 32'(expFlushes)} : 96'd0;
      testCount++;
      assert (got === exp) else begin
         failCount++;
         $error("[TB] FAIL %s counters{cycle,stall,flush} got %0d/%0d/%0d expected %0d/%0d/%0d",
                tag, got[95:64], got[63:32], got[31:0], exp[95:64], exp[63:32], exp[31:0]);
      end
   endtask

   // One cycle: drive inputs, check outputs mid-cycle, then advance the counter model.
   task automatic step(input string tag,
                       input logic ws, input logic br, input logic tk, input logic jal,
                       input logic jalr, input logic hr, input logic rr,
                       input logic pcwe, input logic ns, input logic bub, input logic fl,
                       input logic hl, input logic [1:0] sel);
      applyStimulus(ws, br, tk, jal, jalr, hr, rr);
      @(negedge clock);
      checkOutput(tag, pcwe, ns, bub, fl, hl, sel);
      @(posedge clock);
      expCycles++;
      if (!ns) expStalls++;
      if (fl)  expFlushes++;
      #1;
   endtask

   initial begin
      #2;
      checkOutput("reset_outputs", 0, 0, 1, 0, 0, 2'd0);
      checkCounters("reset_counters");
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;

      for (int i = 0; i < 4; i++)
         step("idle", 0,0,0,0,0,0,0, 1,1,0,0,0,2'd0);
      checkCounters("after_idle");

      step("stall_c1", 1,0,0,0,0,0,0, 0,0,1,0,0,2'd0);
      step("stall_c2", 1,0,0,0,0,0,0, 1,1,0,0,0,2'd0);
      checkCounters("after_stall");

      step("jalr_over_stall", 1,0,0,0,1,0,0, 1,1,1,1,0,2'd2);
      step("redirect_cycle",  1,0,0,0,1,0,0, 1,1,1,1,0,2'd0);
      step("post_redirect",   0,0,0,0,0,0,0, 1,1,0,0,0,2'd0);
      checkCounters("after_jalr");

      step("branch_not_taken", 0,1,0,0,0,0,0, 1,1,0,0,0,2'd0);
      step("jal",              0,0,0,1,0,0,0, 1,1,1,1,0,2'd1);
      step("jal_redirect",     0,0,0,0,0,0,0, 1,1,1,1,0,2'd0);

      step("stall_before_br",  1,0,0,0,0,0,0, 0,0,1,0,0,2'd0);
      step("branch_in_lstall", 1,1,1,0,0,0,0, 1,1,1,1,0,2'd1);
      step("br_redirect",      0,0,0,0,0,0,0, 1,1,1,1,0,2'd0);

      step("halt_req",   0,0,0,0,0,1,0, 0,1,1,0,0,2'd0);
      step("drain1",     0,0,0,1,0,0,0, 0,0,1,0,0,2'd0);
      step("drain2",     0,0,0,0,0,0,0, 0,0,1,0,0,2'd0);
      step("drain3",     0,0,0,0,0,0,0, 0,0,1,0,0,2'd0);
      step("halt1",      0,0,0,0,0,1,0, 0,0,1,0,1,2'd0);
      step("halt2",      0,0,0,0,0,1,0, 0,0,1,0,1,2'd0);
      step("resume_cyc", 0,0,0,0,0,0,1, 0,0,1,0,1,2'd0);
      step("resumed",    0,0,0,0,0,0,0, 1,1,0,0,0,2'd0);
      checkCounters("after_halt");

      step("stall_over_halt", 1,0,0,0,0,1,0, 0,0,1,0,0,2'd0);
      step("lstall_halt_ign", 1,0,0,0,0,1,0, 1,1,0,0,0,2'd0);
      step("halt_req2",       0,0,0,0,0,1,0, 0,1,1,0,0,2'd0);
      step("drain_b1",        0,0,0,0,0,0,0, 0,0,1,0,0,2'd0);

      reset = 1'b0;
      #2;
      expCycles = 0; expStalls = 0; expFlushes = 0;
      checkOutput("reset_in_drain", 0, 0, 1, 0, 0, 2'd0);
      checkCounters("reset_in_drain_cnt");
      @(posedge clock);
      #1 reset = 1'b1;
      step("run_after_reset", 0,0,0,0,0,0,0, 1,1,0,0,0,2'd0);
      step("run_after_reset2", 0,0,0,0,0,0,0, 1,1,0,0,0,2'd0);
      checkCounters("after_reset_release");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
